// File: rtl/alu_seq_if.sv
// Operation request and result bus for alu_seq.
// The master issues operations and the slave (the ALU) returns results and flags.
interface alu_seq_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       alu_fun;
    logic             out_valid;
    logic [WIDTH-1:0] alu_out;
    logic             carry_flag;
    logic             arith_flag;
    logic             logic_flag;
    logic             cmp_flag;
    logic             shift_flag;
    logic             err_flag;

    modport master (
        output in_valid, a, b, alu_fun,
        input  in_ready, out_valid, alu_out,
        input  carry_flag, arith_flag, logic_flag, cmp_flag, shift_flag, err_flag
    );

    modport slave (
        input  in_valid, a, b, alu_fun,
        output in_ready, out_valid, alu_out,
        output carry_flag, arith_flag, logic_flag, cmp_flag, shift_flag, err_flag
    );
endinterface

// File: rtl/alu_seq.sv
// Handshaked ALU: one-cycle operations plus a WIDTH-cycle restoring divider,
// with a registered result, a one-cycle out_valid pulse and class/error flags.
module alu_seq #(
    parameter int WIDTH = 16
) (
    input logic      clk,
    input logic      rst,
    alu_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_SUB   = 4'h1;
    localparam logic [3:0] OP_MUL   = 4'h2;
    localparam logic [3:0] OP_DIV   = 4'h3;
    localparam logic [3:0] OP_AND   = 4'h4;
    localparam logic [3:0] OP_OR    = 4'h5;
    localparam logic [3:0] OP_NAND  = 4'h6;
    localparam logic [3:0] OP_NOR   = 4'h7;
    localparam logic [3:0] OP_XOR   = 4'h8;
    localparam logic [3:0] OP_XNOR  = 4'h9;
    localparam logic [3:0] OP_CMPEQ = 4'hA;
    localparam logic [3:0] OP_CMPG  = 4'hB;
    localparam logic [3:0] OP_CMPL  = 4'hC;
    localparam logic [3:0] OP_SHR   = 4'hD;
    localparam logic [3:0] OP_SHL   = 4'hE;

    typedef enum logic {IDLE, DIV} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             load;
    logic [WIDTH-1:0] res_d;
    logic             carry_d, arith_d, logic_d, cmp_d, shift_d, err_d;

    logic             out_valid_q;
    logic [WIDTH-1:0] alu_out_q;
    logic             carry_q, arith_q, logic_q, cmp_q, shift_q, err_q;

    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   op_res;
    logic               op_carry;

    logic [WIDTH:0]   trial;
    logic             no_borrow;
    logic [WIDTH-1:0] diff;

    assign sum  = {1'b0, bus.a} + {1'b0, bus.b};
    assign prod = {{WIDTH{1'b0}}, bus.a} * {{WIDTH{1'b0}}, bus.b};

    // The partial remainder is always below the divisor, so WIDTH bits are
    // stored and only the shifted trial value needs the extra bit.
    assign trial     = {rem_q, quo_q[WIDTH-1]};
    assign no_borrow = (trial >= {1'b0, dvs_q});
    assign diff      = trial[WIDTH-1:0] - dvs_q;

    always_comb begin
        op_res   = '0;
        op_carry = 1'b0;
        case (bus.alu_fun)
            OP_ADD: begin
                op_res   = sum[WIDTH-1:0];
                op_carry = sum[WIDTH];
            end
            OP_SUB: begin
                op_res   = bus.a - bus.b;
                op_carry = (bus.a < bus.b);
            end
            OP_MUL: begin
                op_res   = prod[WIDTH-1:0];
                op_carry = |prod[2*WIDTH-1:WIDTH];
            end
            OP_AND:   op_res = bus.a & bus.b;
            OP_OR:    op_res = bus.a | bus.b;
            OP_NAND:  op_res = ~(bus.a & bus.b);
            OP_NOR:   op_res = ~(bus.a | bus.b);
            OP_XOR:   op_res = bus.a ^ bus.b;
            OP_XNOR:  op_res = ~(bus.a ^ bus.b);
            OP_CMPEQ: op_res = (bus.a == bus.b) ? WIDTH'(1) : '0;
            OP_CMPG:  op_res = (bus.a > bus.b)  ? WIDTH'(2) : '0;
            OP_CMPL:  op_res = (bus.a < bus.b)  ? WIDTH'(3) : '0;
            OP_SHR:   op_res = {1'b0, bus.a[WIDTH-1:1]};
            OP_SHL:   op_res = {bus.a[WIDTH-2:0], 1'b0};
            default:  op_res = '0;
        endcase
    end

    // Next state, divider step and the result/flag bundle loaded on out_valid.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        res_d   = '0;
        carry_d = 1'b0;
        arith_d = 1'b0;
        logic_d = 1'b0;
        cmp_d   = 1'b0;
        shift_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    if (bus.alu_fun == OP_DIV) begin
                        if (bus.b == '0) begin
                            load    = 1'b1;
                            arith_d = 1'b1;
                            err_d   = 1'b1;
                        end else begin
                            rem_d   = '0;
                            quo_d   = bus.a;
                            dvs_d   = bus.b;
                            cnt_d   = '0;
                            state_d = DIV;
                        end
                    end else begin
                        load    = 1'b1;
                        res_d   = op_res;
                        carry_d = op_carry;
                        arith_d = (bus.alu_fun <= OP_MUL);
                        logic_d = (bus.alu_fun >= OP_AND) && (bus.alu_fun <= OP_XNOR);
                        cmp_d   = (bus.alu_fun >= OP_CMPEQ) && (bus.alu_fun <= OP_CMPL);
                        shift_d = (bus.alu_fun == OP_SHR) || (bus.alu_fun == OP_SHL);
                    end
                end
            end
            DIV: begin
                rem_d = no_borrow ? diff : trial[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], no_borrow};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    load    = 1'b1;
                    res_d   = quo_d;
                    arith_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            alu_out_q   <= '0;
            carry_q     <= 1'b0;
            arith_q     <= 1'b0;
            logic_q     <= 1'b0;
            cmp_q       <= 1'b0;
            shift_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            cnt_q       <= cnt_d;
            out_valid_q <= load;
            if (load) begin
                alu_out_q <= res_d;
                carry_q   <= carry_d;
                arith_q   <= arith_d;
                logic_q   <= logic_d;
                cmp_q     <= cmp_d;
                shift_q   <= shift_d;
                err_q     <= err_d;
            end
        end
    end

    assign bus.in_ready   = (state_q == IDLE);
    assign bus.out_valid  = out_valid_q;
    assign bus.alu_out    = alu_out_q;
    assign bus.carry_flag = carry_q;
    assign bus.arith_flag = arith_q;
    assign bus.logic_flag = logic_q;
    assign bus.cmp_flag   = cmp_q;
    assign bus.shift_flag = shift_q;
    assign bus.err_flag   = err_q;
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: a 16-bit and an 8-bit instance on one clock,
// expected results queued when an operation is driven and popped on out_valid.
module tb_alu_seq;
    typedef struct packed {
        logic [31:0] res;
        logic [5:0]  flg;
    } exp_t;

    typedef struct packed {
        logic [3:0]  f;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic [5:0]  flg;
    } vec_t;

    // Flag vectors ordered {carry, arith, logic, cmp, shift, err}.
    localparam logic [5:0] F_NONE   = 6'b000000;
    localparam logic [5:0] F_ARITH  = 6'b010000;
    localparam logic [5:0] F_CARRY  = 6'b110000;
    localparam logic [5:0] F_LOGIC  = 6'b001000;
    localparam logic [5:0] F_CMP    = 6'b000100;
    localparam logic [5:0] F_SHIFT  = 6'b000010;
    localparam logic [5:0] F_DIVERR = 6'b010001;

    logic clk = 1'b0;
    logic rst16;
    logic rst8;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb16[$];
    exp_t sb8[$];

    alu_seq_if #(.WIDTH(16)) bus16();
    alu_seq_if #(.WIDTH(8))  bus8();

    alu_seq #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst16), .bus(bus16));
    alu_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst8),  .bus(bus8));

    always #5 clk = ~clk;

    function automatic exp_t obs16();
        exp_t o;
        o.res = {16'h0, bus16.alu_out};
        o.flg = {bus16.carry_flag, bus16.arith_flag, bus16.logic_flag,
                 bus16.cmp_flag, bus16.shift_flag, bus16.err_flag};
        return o;
    endfunction

    function automatic exp_t obs8();
        exp_t o;
        o.res = {24'h0, bus8.alu_out};
        o.flg = {bus8.carry_flag, bus8.arith_flag, bus8.logic_flag,
                 bus8.cmp_flag, bus8.shift_flag, bus8.err_flag};
        return o;
    endfunction

    task automatic drive16(input vec_t v);
        exp_t e;
        bus16.in_valid = 1'b1;
        bus16.alu_fun  = v.f;
        bus16.a        = v.a;
        bus16.b        = v.b;
        e.res = {16'h0, v.res};
        e.flg = v.flg;
        sb16.push_back(e);
    endtask

    task automatic drive8(input vec_t v);
        exp_t e;
        bus8.in_valid = 1'b1;
        bus8.alu_fun  = v.f;
        bus8.a        = v.a[7:0];
        bus8.b        = v.b[7:0];
        e.res = {24'h0, v.res[7:0]};
        e.flg = v.flg;
        sb8.push_back(e);
    endtask

    task automatic test_reset();
        logic [39:0] got;
        logic [39:0] want;
        rst16 = 1'b1;
        rst8  = 1'b1;
        bus16.in_valid = 1'b1;
        bus16.alu_fun  = 4'h0;
        bus16.a        = 16'd1;
        bus16.b        = 16'd1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        want = {1'b1, 1'b0, 38'h0};
        got  = {bus16.in_ready, bus16.out_valid, obs16()};
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL reset16: got %h, want %h", got, want);
        end
        got = {bus8.in_ready, bus8.out_valid, obs8()};
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL reset8: got %h, want %h", got, want);
        end
        rst16 = 1'b0;
        rst8  = 1'b0;
        bus16.in_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus16.out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_wins: got out_valid=%b, want 0", bus16.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        vec_t t [0:2];
        exp_t got;
        exp_t want;
        t[0] = '{4'h0, 16'd6,  16'd7, 16'd13, F_ARITH};
        t[1] = '{4'h1, 16'd15, 16'd4, 16'd11, F_ARITH};
        t[2] = '{4'h2, 16'd4,  16'd3, 16'd12, F_ARITH};
        for (int i = 0; i < 3; i++) begin
            drive16(t[i]);
            @(posedge clk);
            @(negedge clk);
            got  = obs16();
            want = sb16.pop_front();
            vectors++;
            if (bus16.out_valid !== 1'b1 || got !== want) begin
                miscompares++;
                $display("[TB] FAIL b2b[%0d]: got valid=%b out=%h flags=%b, want valid=1 out=%h flags=%b",
                         i, bus16.out_valid, got.res, got.flg, want.res, want.flg);
            end
        end
        bus16.in_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus16.out_valid !== 1'b0 || bus16.alu_out !== 16'd12) begin
            miscompares++;
            $display("[TB] FAIL b2b_hold: got valid=%b out=%h, want valid=0 out=000c",
                     bus16.out_valid, bus16.alu_out);
        end
    endtask

    task automatic test_overflow();
        vec_t t [0:3];
        exp_t got;
        exp_t want;
        t[0] = '{4'h0, 16'hFFFF, 16'h0001, 16'h0000, F_CARRY};
        t[1] = '{4'h1, 16'h0004, 16'h0005, 16'hFFFF, F_CARRY};
        t[2] = '{4'h2, 16'h0100, 16'h0100, 16'h0000, F_CARRY};
        t[3] = '{4'h2, 16'h00FF, 16'h0101, 16'hFFFF, F_ARITH};
        for (int i = 0; i < 4; i++) begin
            drive16(t[i]);
            @(posedge clk);
            @(negedge clk);
            got  = obs16();
            want = sb16.pop_front();
            vectors++;
            if (bus16.out_valid !== 1'b1 || got !== want) begin
                miscompares++;
                $display("[TB] FAIL overflow[%0d]: got valid=%b out=%h flags=%b, want valid=1 out=%h flags=%b",
                         i, bus16.out_valid, got.res, got.flg, want.res, want.flg);
            end
        end
        bus16.in_valid = 1'b0;
    endtask

    task automatic test_logic_cmp_shift();
        vec_t t [0:15];
        exp_t got;
        exp_t want;
        t[0]  = '{4'h4, 16'hAAAA, 16'h5555, 16'h0000, F_LOGIC};
        t[1]  = '{4'h5, 16'hAAAA, 16'h5555, 16'hFFFF, F_LOGIC};
        t[2]  = '{4'h6, 16'hAAAA, 16'h5555, 16'hFFFF, F_LOGIC};
        t[3]  = '{4'h7, 16'hAAAA, 16'h5555, 16'h0000, F_LOGIC};
        t[4]  = '{4'h8, 16'hAAAA, 16'h5555, 16'hFFFF, F_LOGIC};
        t[5]  = '{4'h9, 16'hAAAA, 16'h5555, 16'h0000, F_LOGIC};
        t[6]  = '{4'hA, 16'hAAAA, 16'hAAAA, 16'h0001, F_CMP};
        t[7]  = '{4'hA, 16'hAAAA, 16'h5555, 16'h0000, F_CMP};
        t[8]  = '{4'hB, 16'h000F, 16'h000A, 16'h0002, F_CMP};
        t[9]  = '{4'hB, 16'h000A, 16'h000F, 16'h0000, F_CMP};
        t[10] = '{4'hC, 16'h000A, 16'h000F, 16'h0003, F_CMP};
        t[11] = '{4'hC, 16'h000F, 16'h000A, 16'h0000, F_CMP};
        t[12] = '{4'hD, 16'd14,   16'h0000, 16'd7,    F_SHIFT};
        t[13] = '{4'hE, 16'd6,    16'h0000, 16'd12,   F_SHIFT};
        t[14] = '{4'hD, 16'h8001, 16'h0000, 16'h4000, F_SHIFT};
        t[15] = '{4'hE, 16'h8001, 16'h0000, 16'h0002, F_SHIFT};
        for (int i = 0; i < 16; i++) begin
            drive16(t[i]);
            @(posedge clk);
            @(negedge clk);
            got  = obs16();
            want = sb16.pop_front();
            vectors++;
            if (bus16.out_valid !== 1'b1 || got !== want) begin
                miscompares++;
                $display("[TB] FAIL lcs[%0d]: got valid=%b out=%h flags=%b, want valid=1 out=%h flags=%b",
                         i, bus16.out_valid, got.res, got.flg, want.res, want.flg);
            end
        end
        bus16.in_valid = 1'b0;
    endtask

    task automatic test_div16();
        exp_t got;
        exp_t want;
        drive16('{4'h3, 16'd9, 16'd3, 16'd3, F_ARITH});
        @(posedge clk);
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            vectors++;
            if (bus16.in_ready !== 1'b0 || bus16.out_valid !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL div_busy[%0d]: got ready=%b valid=%b, want ready=0 valid=0",
                         j, bus16.in_ready, bus16.out_valid);
            end
            // Requests while busy must be ignored.
            bus16.in_valid = j[0];
            bus16.alu_fun  = 4'h0;
            bus16.a        = 16'd100;
            bus16.b        = 16'd1;
            @(posedge clk);
        end
        @(negedge clk);
        bus16.in_valid = 1'b0;
        got  = obs16();
        want = sb16.pop_front();
        vectors++;
        if (bus16.out_valid !== 1'b1 || bus16.in_ready !== 1'b1 || got !== want) begin
            miscompares++;
            $display("[TB] FAIL div16: got valid=%b ready=%b out=%h flags=%b, want valid=1 ready=1 out=%h flags=%b",
                     bus16.out_valid, bus16.in_ready, got.res, got.flg, want.res, want.flg);
        end
        repeat (2) @(negedge clk);
        vectors++;
        if (bus16.out_valid !== 1'b0 || bus16.alu_out !== 16'd3) begin
            miscompares++;
            $display("[TB] FAIL div16_after: got valid=%b out=%h, want valid=0 out=0003",
                     bus16.out_valid, bus16.alu_out);
        end
        drive16('{4'h3, 16'd14, 16'd0, 16'd0, F_DIVERR});
        @(posedge clk);
        @(negedge clk);
        bus16.in_valid = 1'b0;
        got  = obs16();
        want = sb16.pop_front();
        vectors++;
        if (bus16.out_valid !== 1'b1 || got !== want) begin
            miscompares++;
            $display("[TB] FAIL div_by_zero: got valid=%b out=%h flags=%b, want valid=1 out=%h flags=%b",
                     bus16.out_valid, got.res, got.flg, want.res, want.flg);
        end
    endtask

    task automatic test_div8_reset();
        vec_t t [0:1];
        exp_t got;
        exp_t want;
        int   n;
        int   pulses;
        @(negedge clk);
        drive8('{4'h3, 16'h00FF, 16'h0010, 16'h000F, F_ARITH});
        @(posedge clk);
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            bus8.in_valid = 1'b0;
            if (bus8.out_valid === 1'b1) break;
            @(posedge clk);
            n++;
        end
        got  = obs8();
        want = sb8.pop_front();
        vectors++;
        if (n != 8 || bus8.out_valid !== 1'b1 || got !== want) begin
            miscompares++;
            $display("[TB] FAIL div8: got latency=%0d out=%h flags=%b, want latency=8 out=%h flags=%b",
                     n, got.res, got.flg, want.res, want.flg);
        end
        // Second divide, aborted by reset on its fourth divider edge.
        bus8.in_valid = 1'b1;
        bus8.alu_fun  = 4'h3;
        bus8.a        = 8'd200;
        bus8.b        = 8'd7;
        @(posedge clk);
        @(negedge clk);
        bus8.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst8 = 1'b1;
        bus8.in_valid = 1'b1;
        bus8.alu_fun  = 4'h0;
        bus8.a        = 8'd1;
        bus8.b        = 8'd1;
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if (bus8.in_ready !== 1'b1 || bus8.out_valid !== 1'b0 || obs8() !== 38'h0) begin
            miscompares++;
            $display("[TB] FAIL div8_reset: got ready=%b valid=%b out=%h flags=%b, want ready=1 valid=0 out=00 flags=000000",
                     bus8.in_ready, bus8.out_valid, bus8.alu_out, obs8().flg);
        end
        rst8 = 1'b0;
        bus8.in_valid = 1'b0;
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus8.out_valid === 1'b1) pulses++;
        end
        vectors++;
        if (pulses != 0) begin
            miscompares++;
            $display("[TB] FAIL div8_abort: got %0d out_valid pulses, want 0", pulses);
        end
        t[0] = '{4'h4, 16'h00FF, 16'h000F, 16'h000F, F_LOGIC};
        t[1] = '{4'hF, 16'h0005, 16'h0003, 16'h0000, F_NONE};
        for (int i = 0; i < 2; i++) begin
            drive8(t[i]);
            @(posedge clk);
            @(negedge clk);
            got  = obs8();
            want = sb8.pop_front();
            vectors++;
            if (bus8.out_valid !== 1'b1 || got !== want) begin
                miscompares++;
                $display("[TB] FAIL nop8[%0d]: got valid=%b out=%h flags=%b, want valid=1 out=%h flags=%b",
                         i, bus8.out_valid, got.res, got.flg, want.res, want.flg);
            end
        end
        bus8.in_valid = 1'b0;
    endtask

    initial begin
        bus16.in_valid = 1'b0;
        bus16.alu_fun  = 4'h0;
        bus16.a        = '0;
        bus16.b        = '0;
        bus8.in_valid  = 1'b0;
        bus8.alu_fun   = 4'h0;
        bus8.a         = '0;
        bus8.b         = '0;
        rst16 = 1'b1;
        rst8  = 1'b1;
        test_reset();
        test_back_to_back();
        test_overflow();
        test_logic_cmp_shift();
        test_div16();
        test_div8_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "[TB] watchdog expired");
    end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked ALU that replaces the fixed 16-bit ALU in the datapath. It accepts one operation per cycle through a valid/ready input handshake. It returns a registered result with a one-cycle OUT_VALID pulse. Division is a WIDTH-cycle iterative restoring divider instead of a combinational one, and the block adds overflow and divide-by-zero reporting.

## Interface
- WIDTH, 16: operand and result width; legal range 4..32.
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  reset; synchronous, active-high.
- IN_VALID  input  1  operation request.
- IN_READY  output  1  high when the block can accept; equals (state == IDLE).
- A  input  WIDTH  operand A; unsigned.
- B  input  WIDTH  operand B; unsigned.
- ALU_FUN  input  4  opcode.
- OUT_VALID  output  1  one-cycle pulse when the result is loaded.
- ALU_OUT  output  WIDTH  result; held until the next result.
- Carry_Flag  output  1  carry, borrow or multiply overflow.
- Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag  output  1 each  class of the last result.
- Err_Flag  output  1  the last operation was a divide by zero.

## Operation
- Accept occurs on a CLK edge where IN_VALID & IN_READY & ~RST. A, B and ALU_FUN are captured on that edge only.
- Opcodes:
  - 0000 ADD: ALU_OUT = low WIDTH bits of A+B. Carry_Flag = carry out.
  - 0001 SUB: ALU_OUT = low WIDTH bits of A-B. Carry_Flag = borrow (A<B).
  - 0010 MUL: ALU_OUT = low WIDTH bits of A*B. Carry_Flag = 1 if the upper WIDTH bits are nonzero.
  - 0011 DIV: ALU_OUT = A/B, truncated.
  - 0100 AND, 0101 OR, 0110 NAND, 0111 NOR, 1000 XOR, 1001 XNOR.
  - 1010 CMPEQ: result 1 if A==B, else 0.
  - 1011 CMPG: result 2 if A>B, else 0.
  - 1100 CMPL: result 3 if A<B, else 0.
  - 1101 SHR: A>>1, zero fill.
  - 1110 SHL: A<<1.
  - 1111 NOP: ALU_OUT = 0 and all flags 0; OUT_VALID still pulses.
- Carry_Flag is 0 for every opcode except ADD, SUB and MUL.
- Class flags are one-hot, loaded with the result:
  - Arith_Flag: opcodes 0000..0011.
  - Logic_Flag: 0100..1001.
  - CMP_Flag: 1010..1100.
  - Shift_Flag: 1101..1110.
- States:
  - IDLE: IN_READY=1.
    - Accept of a non-DIV opcode: load result and flags, stay in IDLE.
    - Accept of DIV with B==0: load ALU_OUT=0, Err_Flag=1, Arith_Flag=1, Carry_Flag=0; stay in IDLE.
    - Accept of DIV with B!=0: clear remainder (WIDTH+1 bits), load the dividend shift register with A and the divisor with B, counter=0, go to DIV.
  - DIV: IN_READY=0; IN_VALID is ignored.
    - Each cycle: shift the remainder left with the next dividend MSB and trial-subtract B.
    - Quotient bit = no borrow; restore the remainder on borrow.
    - The counter increments. On the edge with counter==WIDTH-1, load ALU_OUT with the quotient, load flags (Arith_Flag=1, Err_Flag=0), and return to IDLE.
- Err_Flag is 0 for every result other than divide by zero.
- Reset, any state: state=IDLE, counter=0, ALU_OUT=0, all flags 0, OUT_VALID=0. An in-flight DIV is aborted and produces no OUT_VALID.
- Reset values after the reset edge: IN_READY=1, OUT_VALID=0, ALU_OUT=0, every flag 0.

## Timing
- Non-DIV op or divide by zero, accepted at edge k: OUT_VALID=1 and the result is visible in the cycle after edge k.
  - Latency 1; throughput 1 per cycle; back-to-back accepts are legal.
- DIV with B!=0, accepted at edge k:
  - IN_READY=0 from after edge k through edge k+WIDTH.
  - The result loads at edge k+WIDTH; OUT_VALID is high in the cycle after it.
  - IN_READY=1 in that same cycle, so a new accept can occur at edge k+WIDTH+1.
- OUT_VALID is high exactly one cycle per accepted operation. There is no output back-pressure.
- ALU_OUT and the flags change only on the edges that pulse OUT_VALID, or on reset.
- RST high together with IN_VALID: reset wins and nothing is accepted.

## Test plan
- WIDTH=16, reset, then back-to-back accepts ADD 6,7 / SUB 15,4 / MUL 4,3 -> three consecutive OUT_VALID pulses.
  - Results 13, 11, 12; Arith_Flag=1; Carry_Flag=0.
- WIDTH=16, ADD FFFF+0001 -> ALU_OUT=0000, Carry_Flag=1.
  - SUB 4-5 -> FFFF, Carry_Flag=1.
  - MUL 0100*0100 -> 0000, Carry_Flag=1.
- WIDTH=16, DIV 9/3 -> IN_READY low for 16 cycles; IN_VALID pulses during that window are ignored.
  - OUT_VALID 17 cycles after the accept edge, ALU_OUT=3, Err_Flag=0.
  - DIV 14/0 -> ALU_OUT=0, Err_Flag=1, latency 1.
- WIDTH=16, AAAA op 5555 for AND/OR/NAND/NOR/XOR/XNOR -> 0000/FFFF/FFFF/0000/FFFF/0000, Logic_Flag=1.
  - CMPEQ AAAA,AAAA -> 1.
  - CMPG F,A -> 2; CMPG A,F -> 0.
  - CMPL A,F -> 3; CMP_Flag=1.
  - SHR 14 -> 7; SHL 6 -> 12; Shift_Flag=1.
- WIDTH=8, DIV FF/10 -> 0F after 9 cycles.
  - A second DIV is issued; RST is asserted at its 4th DIV cycle -> no OUT_VALID.
  - After the reset edge: ALU_OUT=0, all flags 0, IN_READY=1.
  - NOP -> OUT_VALID pulse with ALU_OUT=0 and all flags 0.
